// File: rtl/mem_arbiter_pkg.sv
// Shared size/state/owner codes for the byte-serial memory arbiter.
package mem_arbiter_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // address[17:16] value marking the IO region
  localparam logic [1:0] IO_BASE_HI = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_byte_lane.sv
// Byte-count decode, store byte select and little-endian read assembly.
module mem_byte_lane
  import mem_arbiter_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        cap_i,
  input  logic [1:0]  cap_idx_i,
  input  logic [7:0]  din_i,
  input  logic [1:0]  wr_idx_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  size_i,
  output logic [2:0]  nbytes_o,
  output logic [7:0]  wbyte_o,
  output logic [31:0] asm_o
);

  logic [31:0] asm_q, asm_d;

  always_comb begin
    unique case (size_i)
      SZ_B:    nbytes_o = 3'd1;
      SZ_H:    nbytes_o = 3'd2;
      default: nbytes_o = 3'd4;
    endcase
  end

  assign wbyte_o = wdata_i[wr_idx_i*8 +: 8];

  // asm_o includes the byte being captured this cycle so the final word is usable at once
  always_comb begin
    asm_d = asm_q;
    if (clr_i)      asm_d = '0;
    else if (cap_i) asm_d[cap_idx_i*8 +: 8] = din_i;
  end

  assign asm_o = asm_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) asm_q <= '0;
    else         asm_q <= asm_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store onto one byte-wide RAM port.
// Define MEMARB_RR_EN for round-robin arbitration instead of mem-over-IF priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rdy_i,
  input  logic              if_req_i,
  input  logic              if_abort_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_done_o,
  output logic [31:0]       if_inst_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_size_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic              mem_done_o,
  output logic [31:0]       mem_rdata_o,
  input  logic [7:0]        ram_din_i,
  output logic [7:0]        ram_dout_o,
  output logic [ADDR_W-1:0] ram_a_o,
  output logic              ram_wr_o,
  output logic              busy_o
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        nb_q, nb_d;
  logic [2:0]        k_q, k_d;
  logic              pend_q, pend_d;
  logic              hold_q, hold_d;
  logic [31:0]       inst_q, inst_d;
  logic [31:0]       rdata_q, rdata_d;

  logic        if_ok, gnt_mem, gnt_if;
  logic        clr, cap;
  logic [1:0]  lane_size;
  logic [2:0]  lane_nb;
  logic [7:0]  lane_wbyte;
  logic [31:0] lane_asm;

  assign if_ok = if_req_i & ~if_abort_i;

`ifdef MEMARB_RR_EN
  owner_e last_q, last_d;
  assign gnt_mem = mem_req_i & (~if_ok | (last_q == OWN_IF));
`else
  assign gnt_mem = mem_req_i;
`endif
  assign gnt_if    = if_ok & ~gnt_mem;
  assign lane_size = gnt_mem ? mem_size_i : SZ_W;

  mem_byte_lane u_lane (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (clr),
    .cap_i     (cap),
    .cap_idx_i (k_q[1:0] - 2'd1),
    .din_i     (ram_din_i),
    .wr_idx_i  (k_q[1:0]),
    .wdata_i   (wdata_q),
    .size_i    (lane_size),
    .nbytes_o  (lane_nb),
    .wbyte_o   (lane_wbyte),
    .asm_o     (lane_asm)
  );

  // k_q: next byte address to issue; pend_q: byte k_q-1 was addressed last cycle
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    base_d  = base_q;
    wdata_d = wdata_q;
    nb_d    = nb_q;
    k_d     = k_q;
    pend_d  = pend_q;
    hold_d  = hold_q;
    inst_d  = inst_q;
    rdata_d = rdata_q;
`ifdef MEMARB_RR_EN
    last_d  = last_q;
`endif
    clr        = 1'b0;
    cap        = 1'b0;
    ram_a_o    = '0;
    ram_dout_o = '0;
    ram_wr_o   = 1'b0;
    if_done_o  = 1'b0;
    mem_done_o = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (rdy_i) begin
          hold_d = 1'b0;
          if (!hold_q && (gnt_mem || gnt_if)) begin
            if (gnt_mem) begin
              owner_d = OWN_MEM;
              base_d  = mem_addr_i;
              state_d = mem_we_i ? ST_WR : ST_RD;
            end else begin
              owner_d = OWN_IF;
              base_d  = if_addr_i;
              state_d = ST_RD;
            end
`ifdef MEMARB_RR_EN
            last_d  = gnt_mem ? OWN_MEM : OWN_IF;
`endif
            wdata_d = mem_wdata_i;
            nb_d    = lane_nb;
            k_d     = '0;
            pend_d  = 1'b0;
            clr     = 1'b1;
          end
        end
      end
      ST_RD: begin
        if (!rdy_i) begin
          // keep the lost byte's address on the bus so its data is ready when rdy returns
          if (pend_q)           ram_a_o = base_q + ADDR_W'(k_q - 3'd1);
          else if (k_q < nb_q)  ram_a_o = base_q + ADDR_W'(k_q);
        end else if (owner_q == OWN_IF && if_abort_i) begin
          state_d = ST_IDLE;
          pend_d  = 1'b0;
        end else begin
          if (pend_q) begin
            cap = 1'b1;
            if (k_q == nb_q) begin
              state_d = ST_DONE;
              if (owner_q == OWN_IF) inst_d  = lane_asm;
              else                   rdata_d = lane_asm;
            end
          end
          if (k_q < nb_q) begin
            ram_a_o = base_q + ADDR_W'(k_q);
            k_d     = k_q + 3'd1;
            pend_d  = 1'b1;
          end else begin
            pend_d  = 1'b0;
          end
        end
      end
      ST_WR: begin
        ram_a_o    = base_q + ADDR_W'(k_q);
        ram_dout_o = lane_wbyte;
        ram_wr_o   = rdy_i;
        if (rdy_i) begin
          if (k_q == nb_q - 3'd1) state_d = ST_DONE;
          else                    k_d     = k_q + 3'd1;
        end
      end
      ST_DONE: begin
        if_done_o  = rdy_i & (owner_q == OWN_IF);
        mem_done_o = rdy_i & (owner_q == OWN_MEM);
        if (rdy_i) begin
          state_d = ST_IDLE;
          hold_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_IF;
      base_q  <= '0;
      wdata_q <= '0;
      nb_q    <= '0;
      k_q     <= '0;
      pend_q  <= 1'b0;
      hold_q  <= 1'b0;
      inst_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      nb_q    <= nb_d;
      k_q     <= k_d;
      pend_q  <= pend_d;
      hold_q  <= hold_d;
      inst_q  <= inst_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef MEMARB_RR_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) last_q <= OWN_IF;
    else         last_q <= last_d;
  end
`endif

  assign if_inst_o   = inst_q;
  assign mem_rdata_o = rdata_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule
